// File: rtl/lcd_byte_writer.sv
// Sends command/data bytes to a 4-bit character LCD as two timed nibbles, high nibble first.
// Optional macro LCD_CLEAR_DELAY_EN stretches the post-byte gap for clear/home commands.
module lcd_byte_writer #(
  parameter int unsigned SETUP_CYC      = 2,
  parameter int unsigned E_HIGH_CYC     = 12,
  parameter int unsigned NIBBLE_GAP_CYC = 50,
  parameter int unsigned BYTE_GAP_CYC   = 2000,
  parameter int unsigned CLEAR_GAP_CYC  = 82000
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       iInitDone,
  input  logic       iValid,
  input  logic [7:0] iData,
  input  logic       iRS,
  output logic       oReady,
  output logic       LCD_E,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic [3:0] SF_DATA
);

  typedef enum logic [3:0] {
    IDLE,
    HI_SETUP,
    HI_PULSE,
    HI_HOLD,
    NIB_GAP,
    LO_SETUP,
    LO_PULSE,
    LO_HOLD,
    BYTE_GAP
  } state_t;

  localparam logic [16:0] SetupLast  = 17'(SETUP_CYC - 1);
  localparam logic [16:0] PulseLast  = 17'(E_HIGH_CYC - 1);
  localparam logic [16:0] NibGapLast = 17'(NIBBLE_GAP_CYC - 1);
  localparam logic [16:0] ByteLast   = 17'(BYTE_GAP_CYC - 1);
  localparam logic [16:0] ClearLast  = 17'(CLEAR_GAP_CYC - 1);

  state_t      state_q, state_d;
  logic [16:0] cnt_q, cnt_d;
  logic [7:0]  byte_q, byte_d;
  logic        rsLat_q, rsLat_d;
  logic        e_q, e_d;
  logic        rsOut_q, rsOut_d;
  logic [3:0]  sf_q, sf_d;
  logic        accept;
  logic        useClearGap;
  logic [16:0] gapLast;

  assign oReady = (state_q == IDLE) && iInitDone;
  assign accept = iValid && oReady;

`ifdef LCD_CLEAR_DELAY_EN
  assign useClearGap = !rsLat_q && (byte_q == 8'h01 || byte_q == 8'h02 || byte_q == 8'h03);
`else
  assign useClearGap = 1'b0;
`endif

  assign gapLast = useClearGap ? ClearLast : ByteLast;

  // Next state, counter and the registered pin values derived from the next state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 17'd1;
    byte_d  = byte_q;
    rsLat_d = rsLat_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = HI_SETUP;
          byte_d  = iData;
          rsLat_d = iRS;
        end
      end
      HI_SETUP: if (cnt_q == SetupLast)  state_d = HI_PULSE;
      HI_PULSE: if (cnt_q == PulseLast)  state_d = HI_HOLD;
      HI_HOLD:                           state_d = NIB_GAP;
      NIB_GAP:  if (cnt_q == NibGapLast) state_d = LO_SETUP;
      LO_SETUP: if (cnt_q == SetupLast)  state_d = LO_PULSE;
      LO_PULSE: if (cnt_q == PulseLast)  state_d = LO_HOLD;
      LO_HOLD:                           state_d = BYTE_GAP;
      BYTE_GAP: if (cnt_q == gapLast)    state_d = IDLE;
      default:                           state_d = IDLE;
    endcase
    if (state_d != state_q || state_d == IDLE) begin
      cnt_d = 17'd0;
    end

    e_d     = (state_d == HI_PULSE) || (state_d == LO_PULSE);
    rsOut_d = (state_d inside {HI_SETUP, HI_PULSE, HI_HOLD, NIB_GAP,
                               LO_SETUP, LO_PULSE, LO_HOLD}) ? rsLat_d : 1'b0;
    case (state_d)
      HI_SETUP, HI_PULSE, HI_HOLD, NIB_GAP: sf_d = byte_d[7:4];
      LO_SETUP, LO_PULSE, LO_HOLD, BYTE_GAP: sf_d = byte_d[3:0];
      default:                               sf_d = sf_q;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= 17'd0;
      byte_q  <= 8'h00;
      rsLat_q <= 1'b0;
      e_q     <= 1'b0;
      rsOut_q <= 1'b0;
      sf_q    <= 4'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      byte_q  <= byte_d;
      rsLat_q <= rsLat_d;
      e_q     <= e_d;
      rsOut_q <= rsOut_d;
      sf_q    <= sf_d;
    end
  end

  assign LCD_E   = e_q;
  assign LCD_RS  = rsOut_q;
  assign LCD_RW  = 1'b0;
  assign SF_DATA = sf_q;

endmodule
